mem_arbiter: RTL

Single-port memory arbiter for the pipelined ARM core. The instruction-fetch path (IF stage) and the data path (MEM stage) share one synchronous single-port RAM through this block. It grants one access per cycle, with data-side priority and an instruction-starvation guard. It returns read data one cycle after grant and drives stall requests for the hazard logic.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_wait_counter.sv | 42 ++++
 rtl/mem_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the single-port memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 4;

    // Width of the IF starvation counter; holds MAX_WAIT values up to 15.
    localparam int WAIT_W = 4;

    // Which requester owns the read data returning from the RAM this cycle.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        IFETCH = 2'd1,
        DATA   = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Saturating count of consecutive denied IF cycles; sat flags when IF must win.
// Latency: count updates on the clock edge, sat is a decode of the register.
// Backpressure: none; clr has priority over inc.
module arb_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [WAIT_W-1:0] SAT_VAL = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise step up and stick at SAT_VAL.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != SAT_VAL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == SAT_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between IF fetch and MEM data, data first, IF anti-starvation.
// Latency: grant in the request cycle, read data/rvalid one cycle after grant.
// Backpressure: losing requester sees stall_f/stall_m and must hold its request.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              CLK_50,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m
);

    owner_t resp_owner_q;
    owner_t resp_owner_d;
    logic   wait_sat;
    logic   if_forced;
    logic   d_wins;

    // Once IF has waited MAX_WAIT cycles it takes the port even against data.
    // Grants and stalls are gated by reset so nothing leaks out while held in reset.
    always_comb begin
        if_forced = wait_sat & i_req;
        d_wins    = d_req & ~if_forced;
        d_gnt     = reset & d_wins;
        i_gnt     = reset & i_req & ~d_wins;
        stall_f   = reset & i_req & ~i_gnt;
        stall_m   = reset & d_req & ~d_gnt;
    end

    // Count denied IF cycles; any IF grant or idle IF cycle restarts the count.
    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk   (CLK_50),
        .rst_n (reset),
        .inc   (stall_f),
        .clr   (~stall_f),
        .sat   (wait_sat)
    );

    // RAM port follows the granted requester; idle port drives zeros.
    always_comb begin
        mem_en    = i_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_addr  = i_addr;
        end
    end

    // Remember who gets next cycle's read data; writes produce no response.
    always_comb begin
        resp_owner_d = NONE;
        if (i_gnt) begin
            resp_owner_d = IFETCH;
        end else if (d_gnt && !d_we) begin
            resp_owner_d = DATA;
        end
    end

    // Response owner register; reset drops any read still in flight.
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            resp_owner_q <= NONE;
        end else begin
            resp_owner_q <= resp_owner_d;
        end
    end

    // Steer RAM read data to its owner only; the other side sees zero.
    always_comb begin
        i_rvalid = (resp_owner_q == IFETCH);
        d_rvalid = (resp_owner_q == DATA);
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

endmodule
